// File: rtl/add_round_key.sv
// AES AddRoundKey stage: XORs the state with one round key picked at elaboration from the packed schedule.
// Optional macro ADD_ROUND_KEY_COMB_EN makes the stage purely combinational (clk/rst_n then unused).
module add_round_key #(
  parameter int round = 1,
  parameter int NK    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [128*(NK+7)-1:0]   key,
  input  logic [127:0]            state,
  output logic [127:0]            out
);

  localparam int NR    = NK + 6;
  localparam int KEY_W = 128 * (NR + 1);
  // Clamp keeps the part-select in range so the explicit errors below are the ones reported.
  localparam int SLOT  = (round >= 1 && round <= NR + 1) ? round : 1;
  localparam int RK_HI = KEY_W - 1 - 128 * (SLOT - 1);

  generate
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("add_round_key: NK=%0d is not one of 4, 6, 8", NK);
    end
    if (round < 1 || round > NR + 1) begin : g_bad_round
      $error("add_round_key: round=%0d outside 1..%0d", round, NR + 1);
    end
  endgenerate

  logic [127:0] rk;
  assign rk = key[RK_HI -: 128];

`ifdef ADD_ROUND_KEY_COMB_EN
  // Other key slots and the clock/reset pins are intentionally dead in this build.
  logic unused_inputs;
  assign unused_inputs = ^{key, clk, rst_n};

  assign out = state ^ rk;
`else
  logic unused_inputs;
  assign unused_inputs = ^key;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= state ^ rk;
    end
  end
`endif

endmodule

// File: tb/tb_add_round_key.sv
// Scoreboard bench for add_round_key: three instances (AES-128 slots 1 and 11, AES-256 slot 15).
module tb_add_round_key;

  localparam int KW4 = 1408;
  localparam int KW8 = 1920;

  localparam logic [127:0] FIPS_RK    = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_STATE = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] FIPS_OUT   = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
  localparam logic [127:0] PATTERN    = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] ONES       = {128{1'b1}};

  logic             clk;
  logic             rst_n;
  logic [KW4-1:0]   k_r1, k_r11;
  logic [KW8-1:0]   k_r15;
  logic [127:0]     s_r1, s_r11, s_r15;
  logic [127:0]     o_r1, o_r11, o_r15;

  typedef struct {
    logic [127:0] e_r1;
    logic [127:0] e_r11;
    logic [127:0] e_r15;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  add_round_key #(.round(1),  .NK(4)) u_r1 (
    .clk(clk), .rst_n(rst_n), .key(k_r1), .state(s_r1), .out(o_r1)
  );
  add_round_key #(.round(11), .NK(4)) u_r11 (
    .clk(clk), .rst_n(rst_n), .key(k_r11), .state(s_r11), .out(o_r11)
  );
  add_round_key #(.round(15), .NK(8)) u_r15 (
    .clk(clk), .rst_n(rst_n), .key(k_r15), .state(s_r15), .out(o_r15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference slot extraction: shift the wanted slot down to the LSBs.
  function automatic logic [127:0] slot_of(input logic [KW8-1:0] k, input int kw, input int s);
    logic [KW8-1:0] t;
    t = k >> (kw - 128 * s);
    return t[127:0];
  endfunction

  function automatic logic [KW8-1:0] rand_key();
    logic [KW8-1:0] r;
    for (int i = 0; i < KW8 / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_fips();
    k_r1 = '0;
    k_r1[KW4-1 -: 128] = FIPS_RK;
    s_r1 = FIPS_STATE;
    k_r11 = rand_key();
    k_r11[127:0] = ONES;
    s_r11 = '0;
    k_r15 = rand_key();
    k_r15[127:0] = PATTERN;
    s_r15 = PATTERN;
  endtask

  task automatic push_const();
    exp_t e;
    e.e_r1  = FIPS_OUT;
    e.e_r11 = ONES;
    e.e_r15 = '0;
    sb.push_back(e);
  endtask

  task automatic drive_random_and_push();
    exp_t e;
    k_r1  = rand_key();
    s_r1  = rand_state();
    k_r11 = rand_key();
    s_r11 = rand_state();
    k_r15 = rand_key();
    s_r15 = rand_state();
    e.e_r1  = s_r1  ^ slot_of({{(KW8-KW4){1'b0}}, k_r1},  KW4, 1);
    e.e_r11 = s_r11 ^ slot_of({{(KW8-KW4){1'b0}}, k_r11}, KW4, 11);
    e.e_r15 = s_r15 ^ slot_of(k_r15, KW8, 15);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got %h expected an entry", tag, o_r1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_r1"},  o_r1,  e.e_r1);
    check({tag, "_r11"}, o_r11, e.e_r11);
    check({tag, "_r15"}, o_r15, e.e_r15);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_r1"},  o_r1,  '0);
    check({tag, "_r11"}, o_r11, '0);
    check({tag, "_r15"}, o_r15, '0);
  endtask

  initial begin
`ifdef ADD_ROUND_KEY_COMB_EN
    rst_n = 1'b0;
    drive_fips();
    push_const();
    #1;
    pop_check("comb_fips");
    for (int i = 0; i < 4; i++) begin
      drive_random_and_push();
      #1;
      pop_check($sformatf("comb_rand%0d", i));
    end
`else
    rst_n = 1'b1;
    drive_fips();
    #1 rst_n = 1'b0;
    #1;
    check_zero("reset_hold");

    @(negedge clk);
    rst_n = 1'b1;
    push_const();
    @(posedge clk);
    #1;
    pop_check("fips_first_edge");

    for (int i = 0; i < 3; i++) begin
      drive_random_and_push();
      @(posedge clk);
      #1;
      pop_check($sformatf("stream%0d", i));
    end

    // New stimulus is pending when reset hits between edges; that result must never appear.
    drive_random_and_push();
    #3 rst_n = 1'b0;
    #1;
    check_zero("midstream_reset");
    sb.delete();
    @(posedge clk);
    #1;
    check_zero("reset_edge_held");

    @(negedge clk);
    rst_n = 1'b1;
    drive_fips();
    push_const();
    @(posedge clk);
    #1;
    pop_check("fips_after_reset");
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
